// File: rtl/pio_fifo_pair_if.sv
// PIO FIFO pair bus: TX/RX push-pull ports, join config and sticky flags.
// The system side drives TX and drains RX; the machine side does the opposite.
interface pio_fifo_pair_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(2*DEPTH)+1;

  logic             join_tx;
  logic             join_rx;
  logic             tx_push;
  logic [WIDTH-1:0] tx_din;
  logic             tx_pull;
  logic [WIDTH-1:0] tx_dout;
  logic             tx_empty;
  logic             tx_full;
  logic [LW-1:0]    tx_level;
  logic             rx_push;
  logic [WIDTH-1:0] rx_din;
  logic             rx_pull;
  logic [WIDTH-1:0] rx_dout;
  logic             rx_empty;
  logic             rx_full;
  logic [LW-1:0]    rx_level;
  logic [3:0]       flags;
  logic [3:0]       flags_clr;

  modport master (
    output join_tx, join_rx,
    output tx_push, tx_din, tx_pull,
    output rx_push, rx_din, rx_pull,
    output flags_clr,
    input  tx_dout, tx_empty, tx_full, tx_level,
    input  rx_dout, rx_empty, rx_full, rx_level,
    input  flags
  );

  modport slave (
    input  join_tx, join_rx,
    input  tx_push, tx_din, tx_pull,
    input  rx_push, rx_din, rx_pull,
    input  flags_clr,
    output tx_dout, tx_empty, tx_full, tx_level,
    output rx_dout, rx_empty, rx_full, rx_level,
    output flags
  );
endinterface

// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair sharing two DEPTH banks; a join hands both banks to one side.
// Side 0 is TX, side 1 is RX; a mode change flushes both sides for one cycle.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  pio_fifo_pair_if.slave bus
);
  localparam int N  = 2*DEPTH;
  localparam int PW = $clog2(N);
  localparam int LW = PW+1;

  typedef enum logic [1:0] {
    M_NORM,
    M_TXJ,
    M_RXJ
  } mode_e;

  mode_e mode_q, mode_d;
  logic  flush;

  logic [WIDTH-1:0] mem [N];

  logic [LW-1:0]    cap   [2];
  logic [PW-1:0]    base  [2];
  logic [LW-1:0]    lvl_q [2];
  logic [LW-1:0]    lvl_n [2];
  logic [PW-1:0]    wp_q  [2];
  logic [PW-1:0]    rp_q  [2];
  logic [PW-1:0]    waddr [2];
  logic [PW-1:0]    raddr [2];
  logic [WIDTH-1:0] din   [2];
  logic [WIDTH-1:0] dout  [2];

  logic [1:0] push, pull;
  logic [1:0] empty, full;
  logic [1:0] acc, take;
  logic [1:0] over, under;
  logic [3:0] flags_q;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p,
    input logic [LW-1:0] c
  );
    logic [LW-1:0] s;
    s = {1'b0, p} + 1'b1;
    return (s == c) ? '0 : s[PW-1:0];
  endfunction

  always_comb begin
    mode_d = M_NORM;
    unique case (1'b1)
      (bus.join_tx == bus.join_rx): mode_d = M_NORM;
      (bus.join_tx & ~bus.join_rx): mode_d = M_TXJ;
      (bus.join_rx & ~bus.join_tx): mode_d = M_RXJ;
    endcase
  end

  assign flush = (mode_q != mode_d);

  assign push = {bus.rx_push, bus.tx_push};
  assign pull = {bus.rx_pull, bus.tx_pull};
  assign din[0] = bus.tx_din;
  assign din[1] = bus.rx_din;

  // RX lives in the upper bank unless a join gives the whole ring to one side
  always_comb begin
    cap[0]  = LW'(DEPTH);
    cap[1]  = LW'(DEPTH);
    base[0] = '0;
    base[1] = PW'(DEPTH);
    unique case (mode_d)
      M_TXJ: begin
        cap[0]  = LW'(N);
        cap[1]  = '0;
        base[1] = '0;
      end
      M_RXJ: begin
        cap[0]  = '0;
        cap[1]  = LW'(N);
        base[1] = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (lvl_q[i] == '0);
      full[i]  = (lvl_q[i] == cap[i]);
      take[i]  = ~flush & pull[i] & ~empty[i];
      acc[i]   = ~flush & push[i] & (~full[i] | take[i]);
      over[i]  = ~flush & push[i] & ~acc[i];
      under[i] = ~flush & pull[i] & empty[i];
      lvl_n[i] = lvl_q[i] + LW'(acc[i]) - LW'(take[i]);
      waddr[i] = base[i] + wp_q[i];
      raddr[i] = base[i] + rp_q[i];
      dout[i]  = empty[i] ? '0 : mem[raddr[i]];
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    if (reset) begin
      flags_q <= '0;
      for (int i = 0; i < 2; i++) begin
        lvl_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
      end
    end else begin
      flags_q <= (flags_q & ~bus.flags_clr) |
                 {under[1], over[1], under[0], over[0]};
      for (int i = 0; i < 2; i++) begin
        if (flush) begin
          lvl_q[i] <= '0;
          wp_q[i]  <= '0;
          rp_q[i]  <= '0;
        end else begin
          lvl_q[i] <= lvl_n[i];
          if (acc[i])  wp_q[i] <= bump(wp_q[i], cap[i]);
          if (take[i]) rp_q[i] <= bump(rp_q[i], cap[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (acc[i] & ~reset) mem[waddr[i]] <= din[i];
  end

  assign bus.tx_dout  = dout[0];
  assign bus.tx_empty = empty[0];
  assign bus.tx_full  = full[0];
  assign bus.tx_level = lvl_q[0];
  assign bus.rx_dout  = dout[1];
  assign bus.rx_empty = empty[1];
  assign bus.rx_full  = full[1];
  assign bus.rx_level = lvl_q[1];
  assign bus.flags    = flags_q;
endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed bench for pio_fifo_pair: order, flags, joins, flush and reset.
// DEPTH=4, so each side holds 4 words unjoined and 8 when joined.
module tb_pio_fifo_pair;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;
  logic [31:0] q [$];

  always #5 clk = ~clk;

  pio_fifo_pair_if #(.WIDTH(32), .DEPTH(4)) bus ();

  pio_fifo_pair #(.WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(
    input logic        tp,
    input logic [31:0] td,
    input logic        tl,
    input logic        rp,
    input logic [31:0] rd,
    input logic        rl,
    input logic [3:0]  clr
  );
    bus.tx_push   = tp;
    bus.tx_din    = td;
    bus.tx_pull   = tl;
    bus.rx_push   = rp;
    bus.rx_din    = rd;
    bus.rx_pull   = rl;
    bus.flags_clr = clr;
    step();
    bus.tx_push   = 1'b0;
    bus.tx_pull   = 1'b0;
    bus.rx_push   = 1'b0;
    bus.rx_pull   = 1'b0;
    bus.flags_clr = 4'h0;
  endtask

  task automatic push_tx(input logic [31:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic pull_tx();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic push_rx(input logic [31:0] d);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, d, 1'b0, 4'h0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.join_tx   = 1'b0;
    bus.join_rx   = 1'b0;
    bus.tx_push   = 1'b0;
    bus.tx_din    = '0;
    bus.tx_pull   = 1'b0;
    bus.rx_push   = 1'b0;
    bus.rx_din    = '0;
    bus.rx_pull   = 1'b0;
    bus.flags_clr = 4'h0;
    step();
    step();
    reset = 1'b0;

    chk("rst_tx_empty", bus.tx_empty, 1);
    chk("rst_tx_full", bus.tx_full, 0);
    chk("rst_tx_dout", bus.tx_dout, 0);
    chk("rst_tx_level", bus.tx_level, 0);
    chk("rst_rx_empty", bus.rx_empty, 1);
    chk("rst_flags", bus.flags, 0);

    for (int i = 1; i <= 4; i++) push_tx(32'hA0 + i);
    chk("fill_full", bus.tx_full, 1);
    chk("fill_level", bus.tx_level, 4);
    chk("fill_head", bus.tx_dout, 32'hA1);
    push_tx(32'hA5);
    chk("over_flag", bus.flags, 4'b0001);
    chk("over_level", bus.tx_level, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("fwft_order", bus.tx_dout, 32'hA0 + i);
      pull_tx();
    end
    chk("drain_empty", bus.tx_empty, 1);
    chk("drain_dout", bus.tx_dout, 0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0001);
    chk("clr_idle", bus.flags, 0);

    for (int i = 1; i <= 4; i++) push_tx(32'hB0 + i);
    cyc(1'b1, 32'hC5, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    chk("pp_full_level", bus.tx_level, 4);
    chk("pp_full_flags", bus.flags, 0);
    chk("pp_full_head", bus.tx_dout, 32'hB2);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hD1, 1'b1, 4'h0);
    chk("pp_empty_level", bus.rx_level, 1);
    chk("pp_empty_flags", bus.flags, 4'b1000);
    chk("pp_empty_dout", bus.rx_dout, 32'hD1);

    cyc(1'b1, 32'hE1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b1001);
    chk("set_wins", bus.flags, 4'b0001);
    chk("set_wins_lvl", bus.tx_level, 4);

    bus.join_tx = 1'b1;
    step();
    chk("txj_flush_tx", bus.tx_level, 0);
    chk("txj_flush_rx", bus.rx_level, 0);
    chk("txj_flush_flags", bus.flags, 4'b0001);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'hF);
    chk("txj_clr", bus.flags, 0);
    for (int i = 0; i < 8; i++) begin
      push_tx(32'hC0 + i);
      q.push_back(32'hC0 + i);
      if (i == 6) chk("txj_not_full7", bus.tx_full, 0);
    end
    chk("txj_full", bus.tx_full, 1);
    chk("txj_level", bus.tx_level, 8);
    chk("txj_rx_full", bus.rx_full, 1);
    chk("txj_rx_empty", bus.rx_empty, 1);
    push_rx(32'hEE);
    chk("txj_rx_over", bus.flags, 4'b0100);
    chk("txj_rx_level", bus.rx_level, 0);
    chk("txj_rx_dout", bus.rx_dout, 0);

    for (int i = 0; i < 4; i++) begin
      chk("txj_order", bus.tx_dout, q.pop_front());
      pull_tx();
    end
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        push_tx(32'hD0 + k);
        q.push_back(32'hD0 + k);
      end else begin
        chk("wrap_order", bus.tx_dout, q.pop_front());
        pull_tx();
      end
    end
    chk("wrap_level", bus.tx_level, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain", bus.tx_dout, q.pop_front());
      pull_tx();
    end
    chk("wrap_empty", bus.tx_empty, 1);

    bus.join_tx = 1'b0;
    step();
    chk("norm_flags", bus.flags, 4'b0100);
    for (int i = 1; i <= 3; i++) push_tx(32'hF0 + i);
    chk("pre_rxj_level", bus.tx_level, 3);

    bus.join_rx = 1'b1;
    cyc(1'b1, 32'h99, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0);
    chk("rxj_tx_level", bus.tx_level, 0);
    chk("rxj_rx_level", bus.rx_level, 0);
    chk("rxj_flags", bus.flags, 4'b0100);
    chk("rxj_tx_full", bus.tx_full, 1);
    chk("rxj_tx_empty", bus.tx_empty, 1);
    for (int i = 0; i < 8; i++) push_rx(32'hE0 + i);
    chk("rxj_rx_full", bus.rx_full, 1);
    chk("rxj_rx_cap", bus.rx_level, 8);
    chk("rxj_rx_head", bus.rx_dout, 32'hE0);

    bus.join_rx = 1'b0;
    step();
    push_tx(32'h11);
    push_tx(32'h12);
    push_rx(32'h21);
    chk("mid_tx_level", bus.tx_level, 2);
    chk("mid_rx_level", bus.rx_level, 1);
    reset       = 1'b1;
    bus.join_tx = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_tx_level", bus.tx_level, 0);
    chk("rst2_rx_level", bus.rx_level, 0);
    chk("rst2_flags", bus.flags, 0);
    chk("rst2_tx_dout", bus.tx_dout, 0);
    chk("rst2_rx_dout", bus.rx_dout, 0);
    chk("rst2_rx_full", bus.rx_full, 1);
    push_tx(32'h77);
    chk("rst2_noflush", bus.tx_level, 1);
    chk("rst2_head", bus.tx_dout, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pio_fifo_pair.md
PIO_FIFO_PAIR -- requirements
Module: pio_fifo_pair

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 4, entries per direction when unjoined; power of two, >= 2.
REQ-003 Derived LW = clog2(2*DEPTH)+1, width of the level outputs.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 join_tx  in  1  config: give RX storage to TX.
REQ-007 join_rx  in  1  config: give TX storage to RX.
REQ-008 tx_push  in  1  system side writes tx_din into TX.
REQ-009 tx_din  in  WIDTH  TX write data.
REQ-010 tx_pull  in  1  machine side consumes the TX head.
REQ-011 tx_dout  out  WIDTH  TX head entry, first-word-fall-through.
REQ-012 tx_empty, tx_full  out  1 each  TX status.
REQ-013 tx_level  out  LW  TX entries held.
REQ-014 rx_push, rx_din, rx_pull, rx_dout, rx_empty, rx_full, rx_level: same as the TX ports; the machine pushes and the system pulls.
REQ-015 flags  out  4  sticky flags: [0] tx_over, [1] tx_under, [2] rx_over, [3] rx_under.
REQ-016 flags_clr  in  4  write-one-to-clear pulse, bitwise onto flags.

Function
REQ-017 The effective mode SHALL be NORMAL when join_tx equals join_rx (both 0 or both 1), TXJ when only join_tx is 1, and RXJ when only join_rx is 1.
REQ-018 Capacity SHALL be DEPTH/DEPTH in NORMAL, 2*DEPTH/0 in TXJ, and 0/2*DEPTH in RXJ (TX/RX).
REQ-019 A direction with capacity 0 SHALL hold empty=1, full=1, level=0, dout=0.
REQ-020 full SHALL be 1 iff level equals capacity; empty SHALL be 1 iff level is 0.
REQ-021 dout SHALL combinationally show the oldest entry when not empty, and 0 when empty.
REQ-022 A push with full=0 SHALL write din and increment level at the clock edge.
REQ-023 A push with full=1 and no pull in the same cycle SHALL be dropped and SHALL set the matching _over flag.
REQ-024 A pull with empty=0 SHALL advance the read pointer and decrement level.
REQ-025 A pull with empty=1 SHALL leave the state unchanged and SHALL set the matching _under flag.
REQ-026 Push and pull in the same cycle with level between 1 and capacity SHALL both take effect, leaving level unchanged.
REQ-027 Push and pull in the same cycle with empty=1 SHALL accept the push, ignore the pull, and set _under.
REQ-028 Push and pull in the same cycle on a capacity-0 side SHALL set both _over and _under.
REQ-029 Pointers SHALL wrap modulo the current capacity, with no gap or duplicate at the wrap.
REQ-030 In a joined mode both storage banks SHALL form one ring of 2*DEPTH entries.
REQ-031 The block SHALL register the effective mode; a change is detected as the registered mode differing from the current decode.
REQ-032 In the cycle the change is detected, both directions SHALL flush: pointers and levels go to 0.
REQ-033 Pushes and pulls in the flush cycle SHALL be ignored and SHALL NOT set flags.
REQ-034 From the next cycle the new capacities SHALL apply.
REQ-035 A flag set and a flags_clr on the same bit in the same cycle SHALL leave the flag set (set wins).
REQ-036 Flags SHALL change only through REQ-023, 025, 027, 028, 035 and flags_clr; a mode flush SHALL NOT alter them.
REQ-037 Storage contents SHALL need no reset; only pointers, levels, mode register and flags reset.

Reset
REQ-038 When reset=1 at an edge: levels=0, pointers=0, flags=0, and the mode register loads the current decode so no flush follows reset.
REQ-039 Outputs after reset SHALL be as follows.
- NORMAL: empty=1, full=0, dout=0.
- Joined mode: the capacity-0 side as in REQ-019.
REQ-040 Reset SHALL take priority over push, pull, flags_clr and mode-change flush.
REQ-041 A reset in mid-operation SHALL discard all queued data.

Verification
REQ-042 Check NORMAL, DEPTH=4, FWFT order.
- Stimulus: push A1..A4 to TX.
- Required: tx_full=1, tx_level=4.
- Stimulus: a 5th push of A5.
- Required: tx_over=1, A5 dropped; four pulls return A1..A4; then tx_empty=1, tx_dout=0.
REQ-043 Check same-cycle push and pull.
- Full TX, push+pull together: level stays 4, no flag set.
- Empty RX, push+pull together: rx_level=1, rx_under=1.
REQ-044 Check TXJ mode.
- Stimulus: join_tx=1.
- Required: one flush cycle, then 8 pushes accepted and tx_full=1 at level 8; rx_full=rx_empty=1.
- Stimulus: one rx_push.
- Required: rx_over=1.
- Stimulus: 12 alternating push/pull cycles that cross the wrap.
- Required: data stays in order.
REQ-045 Check mode change with data queued.
- Stimulus: TX holds 3 words, then switch to RXJ with a push asserted in the flush cycle.
- Required: both levels 0, the push is ignored, flags unchanged, rx capacity becomes 8.
REQ-046 Check flag clear.
- flags_clr=4'b0001 in a cycle with no event: tx_over clears.
- A tx_over event in the same cycle as the clear: tx_over stays 1.
REQ-047 Check reset mid-operation.
- Stimulus: reset with both FIFOs partly full.
- Required: next cycle all levels 0, flags 0, dout 0, and no flush cycle.
